// File: rtl/cmat2x2_operand_loader.sv
// Purpose: assembles a serial stream of 8 complex beats (A[0..3], B[0..3]) into parallel 2x2 operand matrices, double-banked.
// Latency: m_valid rises the cycle after the edge that accepts the 8th beat of a well-formed frame.
// Backpressure: s_ready = bank space free (registered only); m_valid holds the presented frame stable until m_ready.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   s_valid/s_ready         input beat handshake; s_re/s_im element, s_last marks beat 8
//   m_valid/m_ready         output frame handshake
//   Ar, Ai, Br, Bi          packed 4-element matrices, element k at [k*W +: W] (row-major, element 0 in LSBs)
//   err                     one-cycle pulse after a beat with a framing error
module cmat2x2_operand_loader #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [W-1:0]   s_re,
    input  logic [W-1:0]   s_im,
    input  logic           s_last,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [4*W-1:0] Ar,
    output logic [4*W-1:0] Ai,
    output logic [4*W-1:0] Br,
    output logic [4*W-1:0] Bi,
    output logic           err
);

    // Each bank holds one frame: slots 0..3 are A, slots 4..7 are B.
    logic [W-1:0] re_bank_q [2][8];
    logic [W-1:0] im_bank_q [2][8];

    logic [2:0] idx_q;
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] cnt_q;
    logic       err_q;

    logic accept;
    logic at_last_idx;
    logic commit;
    logic frame_err;
    logic pop;

    always_comb begin
        s_ready     = (cnt_q != 2'd2);
        m_valid     = (cnt_q != 2'd0);
        err         = err_q;
        accept      = s_valid && s_ready;
        at_last_idx = (idx_q == 3'd7);
        commit      = accept && at_last_idx && s_last;
        // s_last must coincide exactly with the 8th beat; either mismatch is an error.
        frame_err   = accept && (s_last != at_last_idx);
        pop         = m_valid && m_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= 3'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            err_q    <= 1'b0;
        end else begin
            err_q <= frame_err;
            if (accept) begin
                // An errored frame is simply abandoned: the write bank is reused from slot 0.
                if (commit || frame_err) begin
                    idx_q <= 3'd0;
                end else begin
                    idx_q <= idx_q + 3'd1;
                end
            end
            if (commit) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, commit} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < 8; k++) begin
                    re_bank_q[b][k] <= '0;
                    im_bank_q[b][k] <= '0;
                end
            end
        end else if (accept) begin
            re_bank_q[wr_ptr_q][idx_q] <= s_re;
            im_bank_q[wr_ptr_q][idx_q] <= s_im;
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_out
        assign Ar[k*W +: W] = re_bank_q[rd_ptr_q][k];
        assign Ai[k*W +: W] = im_bank_q[rd_ptr_q][k];
        assign Br[k*W +: W] = re_bank_q[rd_ptr_q][k+4];
        assign Bi[k*W +: W] = im_bank_q[rd_ptr_q][k+4];
    end

endmodule

// File: tb/tb_cmat2x2_operand_loader.sv
// Purpose: randomized and directed bench for cmat2x2_operand_loader against a frame-queue reference model.
// Latency: outputs sampled on the falling edge, inputs driven 1 time unit after the rising edge.
// Backpressure: model predicts s_ready from the number of complete frames not yet consumed.
module tb_cmat2x2_operand_loader;

    localparam int W = 8;

    typedef struct packed {
        logic [4*W-1:0] ar;
        logic [4*W-1:0] ai;
        logic [4*W-1:0] br;
        logic [4*W-1:0] bi;
    } frame_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           s_valid;
    logic           s_ready;
    logic [W-1:0]   s_re;
    logic [W-1:0]   s_im;
    logic           s_last;
    logic           m_valid;
    logic           m_ready;
    logic [4*W-1:0] Ar;
    logic [4*W-1:0] Ai;
    logic [4*W-1:0] Br;
    logic [4*W-1:0] Bi;
    logic           err;

    always #5 clk = ~clk;

    cmat2x2_operand_loader #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_re    (s_re),
        .s_im    (s_im),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .Ar      (Ar),
        .Ai      (Ai),
        .Br      (Br),
        .Bi      (Bi),
        .err     (err)
    );

    int     passed = 0;
    int     total  = 0;
    frame_t exp_q[$];     // complete frames committed but not yet consumed
    frame_t cur;          // frame under assembly
    int     pos;          // beats of cur received so far
    bit     exp_err;      // err expected in the coming cycle
    int     cyc;
    int     mv_cyc[$];    // cycles in which the DUT showed m_valid with m_ready high

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        total++;
        assert (obs === exp_v) begin
            passed++;
        end else begin
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pos     = 0;
        exp_err = 0;
        cur     = '0;
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model, step past the rising edge.
    task automatic tick(input logic v, input logic [W-1:0] re, input logic [W-1:0] im,
                        input logic last, input logic mr, output bit acc);
        frame_t head;
        s_valid = v;
        s_re    = re;
        s_im    = im;
        s_last  = last;
        m_ready = mr;
        @(negedge clk);
        chk("s_ready", s_ready, exp_q.size() < 2);
        chk("m_valid", m_valid, exp_q.size() > 0);
        chk("err", err, exp_err);
        if (exp_q.size() > 0) chk("frame", {Ar, Ai, Br, Bi}, exp_q[0]);
        if (m_valid === 1'b1 && mr) mv_cyc.push_back(cyc);
        acc = v && (exp_q.size() < 2);
        if (mr && exp_q.size() > 0) head = exp_q.pop_front();
        exp_err = 0;
        if (acc) begin
            if (pos < 4) begin
                cur.ar[pos*W +: W] = re;
                cur.ai[pos*W +: W] = im;
            end else begin
                cur.br[(pos-4)*W +: W] = re;
                cur.bi[(pos-4)*W +: W] = im;
            end
            if (last != (pos == 7)) begin
                exp_err = 1;
                pos     = 0;
            end else if (pos == 7) begin
                exp_q.push_back(cur);
                pos = 0;
            end else begin
                pos++;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // mode: 0 well-formed, 1 s_last on beat 5, 2 beat 8 without s_last, 3 single beat with s_last
    task automatic send_frame(input frame_t f, input int mode, input int gap_pct, input logic mr);
        int         nb;
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic       last;
        bit         acc;
        int         tries;
        nb = (mode == 1) ? 5 : ((mode == 3) ? 1 : 8);
        for (int b = 0; b < nb; b++) begin
            re   = (b < 4) ? f.ar[b*W +: W] : f.br[(b-4)*W +: W];
            im   = (b < 4) ? f.ai[b*W +: W] : f.bi[(b-4)*W +: W];
            last = (b == nb - 1) && (mode != 2);
            while (int'($urandom_range(99)) < gap_pct)
                tick(1'b0, W'($urandom), W'($urandom), 1'($urandom), mr, acc);
            acc   = 0;
            tries = 0;
            while (!acc && tries < 40) begin
                tick(1'b1, re, im, last, mr, acc);
                tries++;
            end
            chk("beat_accept", acc, 1'b1);
        end
    endtask

    task automatic drain();
        bit a;
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            tick(1'b0, '0, '0, 1'b0, 1'b1, a);
            n++;
        end
        tick(1'b0, '0, '0, 1'b0, 1'b1, a);
    endtask

    function automatic frame_t rand_frame();
        frame_t f;
        f.ar = (4*W)'($urandom);
        f.ai = (4*W)'($urandom);
        f.br = (4*W)'($urandom);
        f.bi = (4*W)'($urandom);
        return f;
    endfunction

    initial begin
        frame_t fd;
        frame_t f1;
        frame_t f2;
        frame_t f3;
        bit     a;

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_re    = '0;
        s_im    = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        cyc     = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_err", err, 1'b0);
        chk("rst_outputs", {Ar, Ai, Br, Bi}, '0);
        rst_n = 1'b1;
        tick(1'b0, '0, '0, 1'b0, 1'b0, a);
        chk("post_rst_outputs", {Ar, Ai, Br, Bi}, '0);

        // Single directed frame, held without m_ready
        fd.ar = 32'h07FB0301;   // 1, 3, -5, 7
        fd.ai = 32'h0006FC02;   // 2, -4, 6, 0
        fd.br = 32'h800002FF;   // -1, 2, 0, -128
        fd.bi = 32'h7F0503FF;   // -1, 3, 5, 127
        send_frame(fd, 0, 0, 1'b0);
        chk("single_m_valid", m_valid, 1'b1);
        repeat (3) tick(1'b0, '0, '0, 1'b0, 1'b0, a);
        chk("single_Ar", Ar, 32'h07FB0301);
        chk("single_Ai", Ai, 32'h0006FC02);
        chk("single_Br", Br, 32'h800002FF);
        chk("single_Bi", Bi, 32'h7F0503FF);
        drain();

        // Back-pressure: two frames fill both banks, third stalls until a pop
        f1 = rand_frame();
        f2 = rand_frame();
        f3 = rand_frame();
        send_frame(f1, 0, 0, 1'b0);
        send_frame(f2, 0, 0, 1'b0);
        chk("bp_full", s_ready, 1'b0);
        repeat (3) tick(1'b1, f3.ar[W-1:0], f3.ai[W-1:0], 1'b0, 1'b0, a);
        tick(1'b1, f3.ar[W-1:0], f3.ai[W-1:0], 1'b0, 1'b1, a);
        chk("bp_reopen", s_ready, 1'b1);
        send_frame(f3, 0, 0, 1'b0);
        drain();

        // Streaming with random input gaps
        for (int i = 0; i < 10; i++) send_frame(rand_frame(), 0, 30, 1'b1);
        drain();

        // Full-rate streaming: one frame every 8 cycles
        mv_cyc.delete();
        for (int i = 0; i < 4; i++) send_frame(rand_frame(), 0, 0, 1'b1);
        drain();
        chk("rate_frames", mv_cyc.size(), 4);
        for (int i = 0; i + 1 < mv_cyc.size(); i++)
            chk("rate_spacing", mv_cyc[i+1] - mv_cyc[i], 8);

        // Framing errors, each followed by a good frame
        send_frame(rand_frame(), 1, 0, 1'b1);
        send_frame(rand_frame(), 0, 0, 1'b1);
        drain();
        send_frame(rand_frame(), 2, 0, 1'b1);
        send_frame(rand_frame(), 0, 0, 1'b1);
        drain();
        send_frame(rand_frame(), 3, 0, 1'b1);
        send_frame(rand_frame(), 3, 0, 1'b1);
        send_frame(rand_frame(), 0, 20, 1'b1);
        drain();

        // Reset while one frame is held and another is partially loaded
        f1 = rand_frame();
        send_frame(f1, 0, 0, 1'b0);
        for (int b = 0; b < 3; b++) tick(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0, a);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("midrst_m_valid", m_valid, 1'b0);
        chk("midrst_s_ready", s_ready, 1'b1);
        chk("midrst_err", err, 1'b0);
        chk("midrst_outputs", {Ar, Ai, Br, Bi}, '0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(rand_frame(), 0, 0, 1'b0);
        tick(1'b0, '0, '0, 1'b0, 1'b0, a);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
